// File: rtl/sa_accept_unit_if.sv
// Request/result bundle for sa_accept_unit: valid/ready request side and valid/ready result side.
// rand_num carries the caller's uniform random fraction.
interface sa_accept_unit_if #(
    parameter int unsigned COST_W = 32,
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned TINV_W = 32,
    parameter int unsigned TAG_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [COST_W-1:0] new_cost;
    logic [COST_W-1:0] old_cost;
    logic [TINV_W-1:0] tinv;
    logic [FRAC_W-1:0] rand_num;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [FRAC_W:0]   out_prob;
    logic              out_accept;
    logic [TAG_W-1:0]  out_tag;

    modport slave (
        input  in_valid, new_cost, old_cost, tinv, rand_num, in_tag, out_ready,
        output in_ready, out_valid, out_prob, out_accept, out_tag
    );

    modport master (
        output in_valid, new_cost, old_cost, tinv, rand_num, in_tag, out_ready,
        input  in_ready, out_valid, out_prob, out_accept, out_tag
    );
endinterface

// File: rtl/sa_accept_unit.sv
// Pipelined simulated-annealing acceptance unit: p = e^-(diff*tinv), accept = le | (rand < p).
// Define SA_ACCEPT_INTERP_EN to add a fifth, linear-interpolation stage on the 2^-f table.
module sa_accept_unit #(
    parameter int unsigned COST_W = 32,
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned TINV_W = 32,
    parameter int unsigned TAG_W  = 4
) (
    input logic             clk,
    input logic             rst,
    sa_accept_unit_if.slave bus
);
    localparam int unsigned XW = FRAC_W + 8;
    localparam int unsigned PW = COST_W + TINV_W;
    localparam int unsigned YW = 2 * FRAC_W + 9;
    localparam logic [FRAC_W:0] LOG2E =
        (FRAC_W+1)'($rtoi(1.4426950409 * (2.0 ** FRAC_W) + 0.5));
    localparam logic [FRAC_W:0] P_ONE = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [8:0]      K_MAX = 9'(FRAC_W);
`ifdef SA_ACCEPT_INTERP_EN
    localparam int unsigned LUT_N = 17;
    localparam int unsigned F3W   = FRAC_W;
`else
    localparam int unsigned LUT_N = 16;
    localparam int unsigned F3W   = 4;
`endif

    // Table entries are rounded at 24 fraction bits, then truncated to FRAC_W.
    function automatic logic [FRAC_W:0] lut_entry(input int unsigned i);
        int unsigned q;
        q = $rtoi((2.0 ** (-(real'(i)) / 16.0)) * 16777216.0 + 0.5);
        return (FRAC_W+1)'(q >> (24 - FRAC_W));
    endfunction

    logic [FRAC_W:0] w_lut [LUT_N];
    for (genvar g = 0; g < LUT_N; g++) begin : g_lut
        assign w_lut[g] = lut_entry(g);
    end

    logic w_adv;
    logic r_ov;
    assign w_adv        = bus.out_ready | ~r_ov;
    assign bus.in_ready = w_adv;

    // S1: signed difference at COST_W+1 bits so large costs never wrap
    logic [COST_W:0]   w_diff;
    logic              w_le;
    logic [COST_W-1:0] w_abs;
    assign w_diff = {1'b0, bus.new_cost} - {1'b0, bus.old_cost};
    assign w_le   = w_diff[COST_W] | (w_diff == '0);
    assign w_abs  = w_diff[COST_W] ? (bus.old_cost - bus.new_cost) : w_diff[COST_W-1:0];

    logic              r_v1, r_le1;
    logic [COST_W-1:0] r_d1;
    logic [TINV_W-1:0] r_tinv1;
    logic [FRAC_W-1:0] r_rand1;
    logic [TAG_W-1:0]  r_tag1;

    // S2: d is integral, so d*tinv is already x in Q.FRAC_W
    logic [PW-1:0] w_xfull;
    logic          w_sat;
    logic [XW-1:0] w_x;
    assign w_xfull = PW'(r_d1) * PW'(r_tinv1);
    assign w_sat   = |w_xfull[PW-1:XW];
    assign w_x     = w_sat ? '1 : w_xfull[XW-1:0];

    logic              r_v2, r_le2, r_sat2;
    logic [XW-1:0]     r_x2;
    logic [FRAC_W-1:0] r_rand2;
    logic [TAG_W-1:0]  r_tag2;

    // S3: convert to base 2, split into integer shift k and fraction f
    logic [YW-1:0]     w_y;
    logic [8:0]        w_k;
    logic [FRAC_W-1:0] w_f;
    assign w_y = YW'(r_x2) * YW'(LOG2E);
    assign w_k = w_y[YW-1:2*FRAC_W];
    assign w_f = w_y[2*FRAC_W-1:FRAC_W];

    logic              r_v3, r_le3, r_sat3;
    logic [8:0]        r_k3;
    logic [F3W-1:0]    r_f3;
    logic [FRAC_W-1:0] r_rand3;
    logic [TAG_W-1:0]  r_tag3;
    logic [3:0]        w_idx3;
    assign w_idx3 = r_f3[F3W-1 -: 4];

    logic              w_fv, w_fle, w_fsat;
    logic [8:0]        w_fk;
    logic [FRAC_W:0]   w_fbase;
    logic [FRAC_W-1:0] w_frand;
    logic [TAG_W-1:0]  w_ftag;

`ifdef SA_ACCEPT_INTERP_EN
    localparam int unsigned IPW = 2 * FRAC_W - 3;

    logic [4:0] w_ia, w_ib;
    assign w_ia = {1'b0, w_idx3};
    assign w_ib = w_ia + 5'd1;

    logic              r_v4, r_le4, r_sat4;
    logic [8:0]        r_k4;
    logic [FRAC_W:0]   r_a4, r_b4;
    logic [FRAC_W-5:0] r_flow4;
    logic [FRAC_W-1:0] r_rand4;
    logic [TAG_W-1:0]  r_tag4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v4    <= 1'b0;
            r_le4   <= 1'b0;
            r_sat4  <= 1'b0;
            r_k4    <= '0;
            r_a4    <= '0;
            r_b4    <= '0;
            r_flow4 <= '0;
            r_rand4 <= '0;
            r_tag4  <= '0;
        end else if (w_adv) begin
            r_v4    <= r_v3;
            r_le4   <= r_le3;
            r_sat4  <= r_sat3;
            r_k4    <= r_k3;
            r_a4    <= w_lut[w_ia];
            r_b4    <= w_lut[w_ib];
            r_flow4 <= r_f3[FRAC_W-5:0];
            r_rand4 <= r_rand3;
            r_tag4  <= r_tag3;
        end
    end

    // S5: interpolate between adjacent table points, slope is non-negative
    logic [FRAC_W:0] w_delta;
    logic [IPW-1:0]  w_ip;
    assign w_delta = r_a4 - r_b4;
    assign w_ip    = IPW'(w_delta) * IPW'(r_flow4);

    assign w_fv    = r_v4;
    assign w_fle   = r_le4;
    assign w_fsat  = r_sat4;
    assign w_fk    = r_k4;
    assign w_fbase = r_a4 - w_ip[IPW-1:FRAC_W-4];
    assign w_frand = r_rand4;
    assign w_ftag  = r_tag4;

    logic w_unused;
    assign w_unused = ^{w_y[FRAC_W-1:0], w_ip[FRAC_W-5:0]};
`else
    assign w_fv    = r_v3;
    assign w_fle   = r_le3;
    assign w_fsat  = r_sat3;
    assign w_fk    = r_k3;
    assign w_fbase = w_lut[w_idx3];
    assign w_frand = r_rand3;
    assign w_ftag  = r_tag3;

    logic w_unused;
    assign w_unused = ^{w_y[FRAC_W-1:0], w_f[FRAC_W-5:0]};
`endif

    logic [FRAC_W:0] w_prob;
    logic            w_acc;
    always_comb begin
        w_prob = '0;
        if (w_fle) begin
            w_prob = P_ONE;
        end else if (!w_fsat && (w_fk <= K_MAX)) begin
            w_prob = w_fbase >> w_fk;
        end
    end
    assign w_acc = w_fle | ({1'b0, w_frand} < w_prob);

    logic [FRAC_W:0]  r_oprob;
    logic             r_oacc;
    logic [TAG_W-1:0] r_otag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_le1   <= 1'b0;
            r_d1    <= '0;
            r_tinv1 <= '0;
            r_rand1 <= '0;
            r_tag1  <= '0;
            r_v2    <= 1'b0;
            r_le2   <= 1'b0;
            r_sat2  <= 1'b0;
            r_x2    <= '0;
            r_rand2 <= '0;
            r_tag2  <= '0;
            r_v3    <= 1'b0;
            r_le3   <= 1'b0;
            r_sat3  <= 1'b0;
            r_k3    <= '0;
            r_f3    <= '0;
            r_rand3 <= '0;
            r_tag3  <= '0;
            r_ov    <= 1'b0;
            r_oprob <= '0;
            r_oacc  <= 1'b0;
            r_otag  <= '0;
        end else if (w_adv) begin
            r_v1    <= bus.in_valid;
            r_le1   <= w_le;
            r_d1    <= w_abs;
            r_tinv1 <= bus.tinv;
            r_rand1 <= bus.rand_num;
            r_tag1  <= bus.in_tag;
            r_v2    <= r_v1;
            r_le2   <= r_le1;
            r_sat2  <= w_sat;
            r_x2    <= w_x;
            r_rand2 <= r_rand1;
            r_tag2  <= r_tag1;
            r_v3    <= r_v2;
            r_le3   <= r_le2;
            r_sat3  <= r_sat2;
            r_k3    <= w_k;
            r_f3    <= w_f[FRAC_W-1 -: F3W];
            r_rand3 <= r_rand2;
            r_tag3  <= r_tag2;
            r_ov    <= w_fv;
            r_oprob <= w_prob;
            r_oacc  <= w_acc;
            r_otag  <= w_ftag;
        end
    end

    assign bus.out_valid  = r_ov;
    assign bus.out_prob   = r_oprob;
    assign bus.out_accept = r_oacc;
    assign bus.out_tag    = r_otag;
endmodule

// File: tb/tb_sa_accept_unit.sv
// Scoreboard bench for sa_accept_unit: directed vectors, backpressure stall and mid-flight reset.
module tb_sa_accept_unit;
`ifdef SA_ACCEPT_INTERP_EN
    localparam int LAT = 5;
    localparam logic [16:0] P21 = 17'h05E2D;
    localparam int TOL = 8;
`else
    localparam int LAT = 4;
    localparam logic [16:0] P21 = 17'h05E84;
    localparam int TOL = 2;
`endif
    localparam logic [16:0] ONE = 17'h10000;

    typedef struct {
        logic [31:0] nc;
        logic [31:0] oc;
        logic [31:0] tv;
        logic [15:0] rn;
        logic [16:0] prob;
        int          tol;
        logic        acc;
    } vec_t;

    typedef struct {
        logic [3:0]  tag;
        logic [16:0] prob;
        int          tol;
        logic        acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sa_accept_unit_if #(.COST_W(32), .FRAC_W(16), .TINV_W(32), .TAG_W(4)) bus ();

    sa_accept_unit #(.COST_W(32), .FRAC_W(16), .TINV_W(32), .TAG_W(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    vec_t vt[9];

    task automatic chk(input string name, input longint got, input longint exp, input int tol);
        longint d;
        d = got - exp;
        if (d < 0) d = -d;
        n_checks++;
        if (d > tol) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (tol %0d) at %0t", name, got, exp, tol,
                     $time);
        end
    endtask

    task automatic send(input vec_t v, input logic [3:0] tag);
        int waited;
        exp_t e;
        waited = 0;
        @(negedge clk);
        bus.new_cost = v.nc;
        bus.old_cost = v.oc;
        bus.tinv     = v.tv;
        bus.rand_num = v.rn;
        bus.in_tag   = tag;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            chk("send_in_ready_timeout", 0, 1, 0);
        end else begin
            @(posedge clk);
            e.tag  = tag;
            e.prob = v.prob;
            e.tol  = v.tol;
            e.acc  = v.acc;
            sb.push_back(e);
        end
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", sb.size(), 0, 0);
    endtask

    // Output monitor: pops on every accepted result and checks hold-stability while stalled.
    logic        held = 1'b0;
    logic [16:0] h_prob;
    logic        h_acc;
    logic [3:0]  h_tag;
    exp_t        m_e;

    always @(negedge clk) begin
        if (rst) begin
            held <= 1'b0;
        end else if (bus.out_valid && !bus.out_ready) begin
            chk("stall_in_ready", bus.in_ready, 0, 0);
            if (held) begin
                chk("stall_prob_stable", bus.out_prob, h_prob, 0);
                chk("stall_acc_stable", bus.out_accept, h_acc, 0);
                chk("stall_tag_stable", bus.out_tag, h_tag, 0);
            end
            held   <= 1'b1;
            h_prob <= bus.out_prob;
            h_acc  <= bus.out_accept;
            h_tag  <= bus.out_tag;
        end else begin
            held <= 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", (sb.size() > 0) ? 1 : 0, 1, 0);
                if (sb.size() > 0) begin
                    m_e = sb.pop_front();
                    chk("out_tag", bus.out_tag, m_e.tag, 0);
                    chk("out_prob", bus.out_prob, m_e.prob, m_e.tol);
                    chk("out_accept", bus.out_accept, m_e.acc, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int nvalid;
        vt[0] = '{32'd1000, 32'd1000, 32'h10000, 16'hFFFF, ONE, 0, 1'b1};
        vt[1] = '{32'd1001, 32'd1000, 32'h10000, 16'h5000, P21, TOL, 1'b1};
        vt[2] = '{32'd1001, 32'd1000, 32'h10000, 16'h6000, P21, TOL, 1'b0};
        vt[3] = '{32'd1100, 32'd1000, 32'h10000, 16'h0000, 17'h0, 0, 1'b0};
        vt[4] = '{32'd10, 32'd500, 32'hFFFFFFFF, 16'hFFFF, ONE, 0, 1'b1};
        vt[5] = '{32'd2000, 32'd1000, 32'h0, 16'hFFFF, ONE, 0, 1'b1};
        vt[6] = '{32'd1002, 32'd1000, 32'h8000, 16'h5000, P21, TOL, 1'b1};
        vt[7] = '{32'hFFFFFFFF, 32'd0, 32'h10000, 16'h0000, 17'h0, 0, 1'b0};
        vt[8] = '{32'd0, 32'hFFFFFFFF, 32'h10000, 16'hFFFF, ONE, 0, 1'b1};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.new_cost  = '0;
        bus.old_cost  = '0;
        bus.tinv      = '0;
        bus.rand_num  = '0;
        bus.in_tag    = '0;

        repeat (3) @(negedge clk);
        chk("reset_out_valid", bus.out_valid, 0, 0);
        chk("reset_out_prob", bus.out_prob, 0, 0);
        chk("reset_out_accept", bus.out_accept, 0, 0);
        chk("reset_out_tag", bus.out_tag, 0, 0);
        rst = 1'b0;

        // Directed vectors, one at a time and then back-to-back
        for (int i = 0; i < 9; i++) send(vt[i], 4'(i));
        drain();

        // Backpressure: 8 back-to-back requests with a 3-cycle consumer stall
        fork
            begin
                for (int i = 0; i < 8; i++) send(vt[i % 9], 4'(i));
            end
            begin
                @(negedge clk);
                repeat (LAT + 1) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();

        // Reset with results in flight
        send(vt[1], 4'd12);
        send(vt[4], 4'd13);
        send(vt[3], 4'd14);
        repeat (LAT - 2) @(posedge clk);
        #1 chk("pre_reset_out_valid", bus.out_valid, 1, 0);
        rst = 1'b1;
        sb.delete();
        #1 chk("reset_async_out_valid", bus.out_valid, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) nvalid++;
        end
        chk("no_stale_after_reset", nvalid, 0, 0);
        send(vt[1], 4'd9);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
